// File: rtl/ows_txn_ctrl.sv
// 1-wire slave transaction sequencer: ROM layer (Read/Match/Skip) followed by the
// memory function layer (write/read streaming from a 16-bit start address).
module ows_txn_ctrl #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 16,
   parameter logic [63:0] DEVICE_UID = 64'h0000_0000_0000_0001
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reset_pulse,
   input  logic [DATA_W-1:0] rx_byte,
   input  logic              rx_valid,
   output logic [DATA_W-1:0] tx_byte,
   output logic              tx_load,
   input  logic              tx_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              selected,
   output logic              busy
);

   localparam int unsigned HI_W = ADDR_W - DATA_W;

   localparam logic [DATA_W-1:0] CMD_READ_ROM  = 'h33;
   localparam logic [DATA_W-1:0] CMD_MATCH_ROM = 'h55;
   localparam logic [DATA_W-1:0] CMD_SKIP_ROM  = 'hCC;
   localparam logic [DATA_W-1:0] CMD_WRITE     = 'h0F;
   localparam logic [DATA_W-1:0] CMD_READ      = 'hF0;

   typedef enum logic [3:0] {
      StIdle, StRomCmd, StMatchRom, StReadRom, StFunCmd, StAddrLo,
      StAddrHi, StWrData, StRdReq, StRdWait, StRdSend, StWaitRst
   } state_e;

   state_e              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wr_mode_q, wr_mode_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic [DATA_W-1:0]   tx_byte_q, tx_byte_d;
   logic                tx_load_q, tx_load_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                mem_we_q, mem_we_d;
   logic                mem_re_q, mem_re_d;
   logic                selected_q, selected_d;
   logic                busy_q, busy_d;

   logic [DATA_W-1:0]   uid_bytes [8];
   logic [DATA_W-1:0]   uid_byte;
   logic [ADDR_W-1:0]   addr_inc;

   for (genvar g = 0; g < 8; g++) begin : g_uid
      assign uid_bytes[g] = DEVICE_UID[g*DATA_W +: DATA_W];
   end

   assign uid_byte = uid_bytes[cnt_q];
   assign addr_inc = addr_q + ADDR_W'(1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wr_mode_d   = wr_mode_q;
      rd_data_d   = rd_data_q;
      tx_byte_d   = tx_byte_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      selected_d  = selected_q;
      tx_load_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;

      if (reset_pulse) begin
         state_d    = StRomCmd;
         selected_d = 1'b0;
         cnt_d      = '0;
      end else begin
         unique case (state_q)
            StIdle: ;
            StRomCmd: begin
               if (rx_valid) begin
                  cnt_d = '0;
                  case (rx_byte)
                     CMD_READ_ROM: begin
                        state_d    = StReadRom;
                        selected_d = 1'b1;
                     end
                     CMD_MATCH_ROM: state_d = StMatchRom;
                     CMD_SKIP_ROM: begin
                        state_d    = StFunCmd;
                        selected_d = 1'b1;
                     end
                     default: state_d = StWaitRst;
                  endcase
               end
            end
            StMatchRom: begin
               if (rx_valid) begin
                  if (rx_byte != uid_byte) begin
                     state_d = StWaitRst;
                  end else if (cnt_q == 3'd7) begin
                     state_d    = StFunCmd;
                     selected_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
            StReadRom: begin
               // tx_load_q guard keeps loads apart while tx_ready lags by a cycle
               if (tx_ready && !tx_load_q) begin
                  tx_load_d = 1'b1;
                  tx_byte_d = uid_byte;
                  cnt_d     = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) state_d = StFunCmd;
               end
            end
            StFunCmd: begin
               if (rx_valid) begin
                  case (rx_byte)
                     CMD_WRITE: begin
                        state_d   = StAddrLo;
                        wr_mode_d = 1'b1;
                     end
                     CMD_READ: begin
                        state_d   = StAddrLo;
                        wr_mode_d = 1'b0;
                     end
                     default: state_d = StWaitRst;
                  endcase
               end
            end
            StAddrLo: begin
               if (rx_valid) begin
                  addr_d[DATA_W-1:0] = rx_byte;
                  state_d            = StAddrHi;
               end
            end
            StAddrHi: begin
               if (rx_valid) begin
                  addr_d[ADDR_W-1:DATA_W] = rx_byte[HI_W-1:0];
                  if (wr_mode_q) begin
                     state_d = StWrData;
                  end else begin
                     // Issue the first read so mem_re is live while in StRdReq
                     state_d    = StRdReq;
                     mem_re_d   = 1'b1;
                     mem_addr_d = {rx_byte[HI_W-1:0], addr_q[DATA_W-1:0]};
                  end
               end
            end
            StWrData: begin
               if (rx_valid) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = rx_byte;
                  mem_addr_d  = addr_q;
                  addr_d      = addr_inc;
               end
            end
            StRdReq:  state_d = StRdWait;
            StRdWait: begin
               rd_data_d = mem_rdata;
               state_d   = StRdSend;
            end
            StRdSend: begin
               if (tx_ready && !tx_load_q) begin
                  tx_load_d  = 1'b1;
                  tx_byte_d  = rd_data_q;
                  addr_d     = addr_inc;
                  mem_re_d   = 1'b1;
                  mem_addr_d = addr_inc;
                  state_d    = StRdReq;
               end
            end
            StWaitRst: ;
            default: state_d = StIdle;
         endcase
      end

      busy_d = !(state_d inside {StIdle, StWaitRst});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         addr_q      <= '0;
         wr_mode_q   <= 1'b0;
         rd_data_q   <= '0;
         tx_byte_q   <= '0;
         tx_load_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         selected_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wr_mode_q   <= wr_mode_d;
         rd_data_q   <= rd_data_d;
         tx_byte_q   <= tx_byte_d;
         tx_load_q   <= tx_load_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         selected_q  <= selected_d;
         busy_q      <= busy_d;
      end
   end

   assign tx_byte   = tx_byte_q;
   assign tx_load   = tx_load_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign selected  = selected_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ows_txn_ctrl.sv
// Directed plus randomized bench for ows_txn_ctrl with a memory/transmitter
// responder and a transaction-level reference model.
module tb_ows_txn_ctrl;

   localparam logic [63:0] UID = 64'h0000_0000_0000_0001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        reset_pulse = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_byte;
   logic        tx_load;
   logic        tx_ready = 1'b0;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata = 8'hEE;
   logic        selected;
   logic        busy;

   ows_txn_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .reset_pulse (reset_pulse),
      .rx_byte     (rx_byte),
      .rx_valid    (rx_valid),
      .tx_byte     (tx_byte),
      .tx_load     (tx_load),
      .tx_ready    (tx_ready),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_re      (mem_re),
      .mem_rdata   (mem_rdata),
      .selected    (selected),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [23:0] wr_q[$];
   logic [7:0]  tx_q[$];
   int          re_cnt = 0;
   int          b2b = 0;
   logic        prev_load = 1'b0;
   logic [7:0]  salt = 8'h00;
   bit          ready_rand = 1'b0;
   logic [63:0] uid_v = UID;

   // Read data is only valid in the single cycle after mem_re
   always @(posedge clk) mem_rdata <= mem_re ? (mem_addr[7:0] ^ salt) : 8'hEE;

   // Transmitter: busy for the cycle after a load, otherwise ready or random
   always @(posedge clk)
      tx_ready <= tx_load ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);

   always @(negedge clk) begin
      if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
      if (tx_load) begin
         tx_q.push_back(tx_byte);
         if (prev_load) b2b <= b2b + 1;
      end
      if (mem_re) re_cnt <= re_cnt + 1;
      prev_load <= tx_load;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      rx_byte  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      rx_byte  = 8'($urandom);
      repeat (gap) step();
   endtask

   task automatic pulse();
      reset_pulse = 1'b1;
      step();
      reset_pulse = 1'b0;
   endtask

   task automatic clear();
      wr_q.delete();
      tx_q.delete();
      re_cnt = 0;
      b2b    = 0;
   endtask

   task automatic wait_tx(input int n, input int limit);
      for (int i = 0; i < limit && tx_q.size() < n; i++) step();
   endtask

   task automatic check_zero(input string pfx);
      chk({pfx, "_selected"}, 32'(selected), 0);
      chk({pfx, "_busy"}, 32'(busy), 0);
      chk({pfx, "_tx_load"}, 32'(tx_load), 0);
      chk({pfx, "_mem_we"}, 32'(mem_we), 0);
      chk({pfx, "_mem_re"}, 32'(mem_re), 0);
      chk({pfx, "_tx_byte"}, 32'(tx_byte), 0);
      chk({pfx, "_mem_addr"}, 32'(mem_addr), 0);
      chk({pfx, "_mem_wdata"}, 32'(mem_wdata), 0);
   endtask

   function automatic logic [7:0] rd_model(input logic [15:0] a);
      return a[7:0] ^ salt;
   endfunction

   logic [15:0] start;
   logic [7:0]  d[8];
   int          n;

   initial begin
      // Power-on reset
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("por");
      rst_n = 1'b1;
      step();
      clear();
      send(8'hCC, 0); send(8'h0F, 0); send(8'h00, 0); send(8'h00, 0); send(8'h11, 2);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_selected", 32'(selected), 0);
      chk("idle_no_writes", wr_q.size(), 0);

      // Skip ROM write: 0xA5 @0x0010, 0x5A @0x0011 with 1-cycle latency
      clear();
      pulse();
      chk("romcmd_busy", 32'(busy), 1);
      send(8'hCC, 1);
      chk("skip_selected", 32'(selected), 1);
      send(8'h0F, 0); send(8'h10, 0); send(8'h00, 0);
      rx_byte = 8'hA5; rx_valid = 1'b1; step();
      rx_byte = 8'h5A;
      chk("wr1_we", 32'(mem_we), 1);
      chk("wr1_addr_data", {mem_addr, mem_wdata}, 24'h0010A5);
      step();
      rx_valid = 1'b0;
      chk("wr2_we", 32'(mem_we), 1);
      chk("wr2_addr_data", {mem_addr, mem_wdata}, 24'h00115A);
      step();
      chk("wr_strobe_one_cycle", 32'(mem_we), 0);
      step();
      chk("wr_count", wr_q.size(), 2);

      // Async reset with a write strobe outstanding
      rx_byte = 8'h3C; rx_valid = 1'b1; step(); rx_valid = 1'b0;
      chk("midwr_we_pending", 32'(mem_we), 1);
      #1 rst_n = 1'b0;
      #1;
      check_zero("midwr");
      #1 rst_n = 1'b1;
      step();
      clear();
      send(8'hCC, 0); send(8'h0F, 0); send(8'h01, 0); send(8'h00, 0); send(8'h77, 2);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_no_writes", wr_q.size(), 0);

      // Match ROM then read from 0xFFFF: wraps to 0x0000, 0x0001
      clear();
      pulse();
      send(8'h55, 0);
      for (int i = 0; i < 8; i++) send(uid_v[8*i +: 8], $urandom_range(0, 2));
      chk("match_selected", 32'(selected), 1);
      send(8'hF0, 0); send(8'hFF, 0); send(8'hFF, 0);
      wait_tx(3, 200);
      pulse();
      step(); step();
      chk("rd_enough", 32'(tx_q.size() >= 3), 1);
      chk("rd_b0", 32'(tx_q[0]), 8'hFF);
      chk("rd_b1", 32'(tx_q[1]), 8'h00);
      chk("rd_b2", 32'(tx_q[2]), 8'h01);
      chk("rd_no_b2b", b2b, 0);

      // Match ROM failure on the first UID byte
      clear();
      pulse();
      send(8'h55, 0);
      send(8'h02, 1);
      chk("mism_busy", 32'(busy), 0);
      chk("mism_selected", 32'(selected), 0);
      send(8'hCC, 0); send(8'h0F, 0); send(8'h00, 0); send(8'h00, 0); send(8'h42, 2);
      chk("mism_no_writes", wr_q.size(), 0);
      chk("mism_no_reads", re_cnt, 0);
      chk("mism_no_tx", tx_q.size(), 0);
      pulse();
      chk("mism_exit_busy", 32'(busy), 1);

      // Read ROM with a stuttering transmitter, then a write command
      clear();
      ready_rand = 1'b1;
      send(8'h33, 0);
      chk("readrom_selected", 32'(selected), 1);
      wait_tx(8, 400);
      step(); step();
      chk("readrom_count", tx_q.size(), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("readrom_b%0d", i), 32'(tx_q[i]), 32'(uid_v[8*i +: 8]));
      chk("readrom_no_b2b", b2b, 0);
      send(8'h0F, 0); send(8'h20, 0); send(8'h00, 0); send(8'h99, 2);
      chk("readrom_fn_count", wr_q.size(), 1);
      chk("readrom_fn_write", wr_q[0], 24'h002099);

      // reset_pulse colliding with a data byte
      clear();
      rx_byte = 8'h77; rx_valid = 1'b1; reset_pulse = 1'b1;
      step();
      rx_valid = 1'b0; reset_pulse = 1'b0;
      chk("coll_we", 32'(mem_we), 0);
      chk("coll_selected", 32'(selected), 0);
      chk("coll_busy", 32'(busy), 1);
      step(); step();
      chk("coll_no_writes", wr_q.size(), 0);
      send(8'hCC, 0);
      chk("coll_romcmd", 32'(selected), 1);

      // Randomized transactions against the model
      for (int it = 0; it < 12; it++) begin
         clear();
         salt       = 8'($urandom);
         ready_rand = 1'($urandom_range(0, 1));
         pulse();
         if ($urandom_range(0, 1) == 0) begin
            send(8'hCC, $urandom_range(0, 1));
         end else begin
            send(8'h55, 0);
            for (int i = 0; i < 8; i++) send(uid_v[8*i +: 8], $urandom_range(0, 1));
         end
         start = ($urandom_range(0, 2) == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 3)))
                                            : 16'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            n = $urandom_range(1, 6);
            send(8'h0F, 0); send(start[7:0], 0); send(start[15:8], 0);
            for (int i = 0; i < n; i++) begin
               d[i] = 8'($urandom);
               send(d[i], $urandom_range(0, 2));
            end
            step(); step();
            pulse();
            step();
            chk($sformatf("rnd%0d_wr_count", it), wr_q.size(), n);
            for (int i = 0; i < n; i++)
               chk($sformatf("rnd%0d_wr%0d", it, i), wr_q[i], {16'(start + 16'(i)), d[i]});
         end else begin
            n = $urandom_range(1, 5);
            send(8'hF0, 0); send(start[7:0], 0); send(start[15:8], 0);
            wait_tx(n, 300);
            pulse();
            step(); step();
            chk($sformatf("rnd%0d_rd_enough", it), 32'(tx_q.size() >= n), 1);
            for (int i = 0; i < tx_q.size(); i++)
               chk($sformatf("rnd%0d_rd%0d", it, i), 32'(tx_q[i]),
                   32'(rd_model(16'(start + 16'(i)))));
            chk($sformatf("rnd%0d_rd_no_b2b", it), b2b, 0);
         end
         chk($sformatf("rnd%0d_sel_clear", it), 32'(selected), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ows_txn_ctrl.md
Name: ows_txn_ctrl

Overview:
Transaction sequencer for the 1-wire slave. It consumes the decoded byte stream from the bit-level receiver and runs the ROM layer (Read/Match/Skip ROM against the device UID). It then runs the function layer (write/read memory with a 16-bit start address). It drives the slave memory port and the byte transmitter, sitting between the bit engine and the memory.

Parameters:
DATA_W, 8, byte width on rx/tx/memory data.
ADDR_W, 16, memory address width; address counter wraps modulo 2^ADDR_W.
DEVICE_UID, 64'h0000_0000_0000_0001, device UID, sent/compared LSB byte first.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
reset_pulse  in  1  one-cycle strobe: 1-wire reset/presence completed
rx_byte  in  DATA_W  received byte
rx_valid  in  1  one-cycle strobe, rx_byte valid
tx_byte  out  DATA_W  byte for transmitter
tx_load  out  1  one-cycle strobe, tx_byte valid
tx_ready  in  1  transmitter can accept a byte
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  write data
mem_we  out  1  one-cycle write strobe
mem_re  out  1  one-cycle read strobe
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_re
selected  out  1  device addressed (Match/Skip/Read ROM passed)
busy  out  1  high in every state except IDLE and WAIT_RST

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0, including selected, tx_load, mem_we, mem_re, tx_byte, mem_addr and mem_wdata. Internal byte count is 0.
- reset_pulse has priority in every state:
  - Next state is ROM_CMD.
  - selected and byte count clear.
  - mem_we, mem_re and tx_load are 0 next cycle; any pending read is dropped.
  - An rx_valid in the same cycle is discarded.
- IDLE: ignores rx_valid until reset_pulse.
- ROM_CMD, on rx_valid:
  - 0x33 -> READ_ROM; selected=1.
  - 0x55 -> MATCH_ROM.
  - 0xCC -> FUN_CMD; selected=1.
  - Other -> WAIT_RST.
- MATCH_ROM: byte i (0..7) is compared with DEVICE_UID[8i+:8].
  - Mismatch -> WAIT_RST, selected stays 0.
  - Match on byte 7 -> FUN_CMD, selected=1.
- READ_ROM: sends 8 UID bytes, LSB byte first.
  - Per byte: when tx_ready=1, drive tx_byte and pulse tx_load for one cycle.
  - tx_load is never asserted on consecutive cycles; the transmitter deasserts tx_ready the cycle after tx_load.
  - After byte 7 -> FUN_CMD.
- FUN_CMD, on rx_valid:
  - 0x0F -> ADDR_LO, write mode.
  - 0xF0 -> ADDR_LO, read mode.
  - Other -> WAIT_RST.
- ADDR_LO/ADDR_HI: capture address LSB then MSB into the address counter.
  - ADDR_HI -> WR_DATA in write mode.
  - ADDR_HI -> RD_REQ in read mode.
- WR_DATA, per rx_valid:
  - Next cycle: mem_we=1, mem_wdata=byte, mem_addr=counter.
  - Counter increments in the cycle after mem_we.
  - Counter wraps 0xFFFF->0x0000.
  - Unlimited bytes until reset_pulse.
- RD_REQ: mem_re=1 for one cycle at the counter address -> RD_WAIT.
- RD_WAIT: latches mem_rdata the next cycle -> RD_SEND.
- RD_SEND: when tx_ready, tx_load=1 with the latched byte, counter +1 (wraps) -> RD_REQ. Streams until reset_pulse.
- rx_valid in READ_ROM and RD_* states is ignored.
- WAIT_RST: all strobes 0; exits only via reset_pulse.
- Output timing: all outputs registered; minimum rx_valid-to-mem_we latency is 1 cycle.

Test Plan:
- rst_n low mid-write (mem_we pending) -> all outputs 0 immediately; after release, state IDLE, busy=0, and rx_valid is ignored until reset_pulse.
- reset_pulse, 0xCC, 0x0F, 0x10, 0x00, data 0xA5,0x5A -> mem_we pulses at addr 0x0010 (0xA5) and 0x0011 (0x5A); selected=1.
- reset_pulse, 0x55, 8 UID bytes matching default, 0xF0, 0xFF, 0xFF with mem model returning addr[7:0] -> tx_load bytes 0xFF,0x00,0x01 (address wrap), with exactly 1 cycle from mem_re to data latch.
- reset_pulse, 0x55, first UID byte 0x02 -> WAIT_RST, selected=0; further bytes produce no mem strobes; next reset_pulse returns to ROM_CMD.
- reset_pulse, 0x33 with tx_ready toggling -> 8 tx_load pulses carrying 0x01,0x00,...,0x00, never back-to-back; then 0x0F accepted as a function command.
- reset_pulse asserted in the same cycle as rx_valid during WR_DATA -> no mem_we for that byte, state ROM_CMD, selected=0.
